// File: rtl/msg_stream_arbiter.sv
// rtl/msg_stream_arbiter.sv - packet-level round-robin arbiter feeding one message extractor
module msg_stream_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS-1:0]          in_startofpacket,
  input  logic [NUM_PORTS-1:0]          in_endofpacket,
  input  logic [NUM_PORTS-1:0]          in_error,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS*EMPTY_W-1:0]  in_empty,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic                          out_valid,
  output logic                          out_startofpacket,
  output logic                          out_endofpacket,
  output logic                          out_error,
  output logic [DATA_W-1:0]             out_data,
  output logic [EMPTY_W-1:0]            out_empty,
  input  logic                          out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          pkt_active,
  output logic [CNT_W-1:0]              orphan_cnt
);

  localparam int GID_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [GID_W-1:0] rr_ptr;

  logic             req_found;
  logic [GID_W-1:0] req_id;
  logic [GID_W-1:0] cand_id;
  int               arb_idx;
  logic             orph_found;
  logic [GID_W-1:0] orph_id;
  logic             accept_eop;

  // Round-robin search for a SOP requester, starting just after the last owner
  always_comb begin
    req_found = 1'b0;
    req_id    = '0;
    arb_idx   = 0;
    cand_id   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      arb_idx = (int'(rr_ptr) + i) % NUM_PORTS;
      cand_id = GID_W'(arb_idx);
      if (!req_found && in_valid[cand_id] && in_startofpacket[cand_id]) begin
        req_found = 1'b1;
        req_id    = cand_id;
      end
    end
  end

  // Lowest-index mid-packet beat gets drained; a port being granted is never a drain target
  always_comb begin
    orph_found = 1'b0;
    orph_id    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!orph_found && in_valid[p] && !in_startofpacket[p] &&
          !(req_found && (req_id == GID_W'(p)))) begin
        orph_found = 1'b1;
        orph_id    = GID_W'(p);
      end
    end
  end

  // Ready steering: granted port follows the extractor while locked, orphan drain while idle
  always_comb begin
    in_ready = '0;
    if (state == LOCKED) begin
      in_ready[grant_id] = out_ready;
    end else if (orph_found) begin
      in_ready[orph_id] = 1'b1;
    end
  end

  // Zero-latency beat mux from the granted port; valid is suppressed outside a lock
  always_comb begin
    out_valid         = (state == LOCKED) && in_valid[grant_id];
    out_startofpacket = in_startofpacket[grant_id];
    out_endofpacket   = in_endofpacket[grant_id];
    out_error         = in_error[grant_id];
    out_data          = in_data[int'(grant_id)*DATA_W +: DATA_W];
    out_empty         = in_empty[int'(grant_id)*EMPTY_W +: EMPTY_W];
    accept_eop        = (state == LOCKED) && in_valid[grant_id] && out_ready &&
                        in_endofpacket[grant_id];
  end

  // Arbitration FSM: grant on SOP, hold until an accepted EOP, count drained orphans
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= GID_W'(NUM_PORTS - 1);
      orphan_cnt <= '0;
      pkt_active <= 1'b0;
    end else if (state == IDLE) begin
      if (orph_found && (orphan_cnt != {CNT_W{1'b1}})) begin
        orphan_cnt <= orphan_cnt + CNT_W'(1);
      end
      if (req_found) begin
        grant_id   <= req_id;
        state      <= LOCKED;
        pkt_active <= 1'b1;
      end
    end else begin
      if (accept_eop) begin
        rr_ptr     <= grant_id;
        state      <= IDLE;
        pkt_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// tb/tb_msg_stream_arbiter.sv - scoreboard bench for msg_stream_arbiter
module tb_msg_stream_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic [NP-1:0]       in_valid = '0, in_startofpacket = '0, in_endofpacket = '0, in_error = '0;
  logic [NP*DW-1:0]    in_data = '0;
  logic [NP*EW-1:0]    in_empty = '0;
  logic [NP-1:0]       in_ready;
  logic                out_valid, out_startofpacket, out_endofpacket, out_error;
  logic [DW-1:0]       out_data;
  logic [EW-1:0]       out_empty;
  logic                out_ready = 1'b1;
  logic [1:0]          grant_id;
  logic                pkt_active;
  logic [CW-1:0]       orphan_cnt;

  msg_stream_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_error(in_error), .in_data(in_data), .in_empty(in_empty), .in_ready(in_ready),
    .out_valid(out_valid), .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_error(out_error), .out_data(out_data), .out_empty(out_empty), .out_ready(out_ready),
    .grant_id(grant_id), .pkt_active(pkt_active), .orphan_cnt(orphan_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  empty;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [1:0] port;
  } exp_t;

  beat_t   src_q[NP][$];
  exp_t    exp_q[$];
  int      xfer_cyc[$];
  int      cyc = 0;
  int      n_xfer = 0;
  logic [NP-1:0] hs = '0;
  int      n_chk = 0;
  int      n_pass = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic beat_t make_beat(input int p, input int n, input int tag, input int i,
                                      input bit sop, input int err_beat);
    beat_t b;
    b.data  = {4'hD, 36'h0, 8'(p), 8'(tag), 8'(i)};
    b.sop   = sop && (i == 0);
    b.eop   = (i == n - 1);
    b.err   = (i == err_beat);
    b.empty = 3'(i);
    return b;
  endfunction

  task automatic push_pkt(input int p, input int n, input int tag, input bit sop, input int err_beat);
    for (int i = 0; i < n; i++) src_q[p].push_back(make_beat(p, n, tag, i, sop, err_beat));
  endtask

  task automatic expect_pkt(input int p, input int n, input int tag, input int err_beat, input int upto);
    exp_t e;
    for (int i = 0; i < upto; i++) begin
      e.b    = make_beat(p, n, tag, i, 1'b1, err_beat);
      e.port = 2'(p);
      exp_q.push_back(e);
    end
  endtask

  function automatic int src_pending();
    int s = 0;
    for (int p = 0; p < NP; p++) s += src_q[p].size();
    return s;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || src_pending() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 80'(k < budget), 80'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input string name);
    int k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (n_xfer != target && k < 30);
    chk(name, 80'(n_xfer), 80'(target));
  endtask

  // Source models: pop on a handshake seen at the previous negedge, present the next beat
  initial forever begin
    beat_t b;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      if (src_q[p].size() > 0) begin
        b = src_q[p][0];
        in_valid[p]            = 1'b1;
        in_startofpacket[p]    = b.sop;
        in_endofpacket[p]      = b.eop;
        in_error[p]            = b.err;
        in_data[p*DW +: DW]    = b.data;
        in_empty[p*EW +: EW]   = b.empty;
      end else begin
        in_valid[p]            = 1'b0;
        in_startofpacket[p]    = 1'b0;
        in_endofpacket[p]      = 1'b0;
        in_error[p]            = 1'b0;
      end
    end
  end

  // Monitor: every beat the extractor accepts is compared against the scoreboard head
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    hs = in_valid & in_ready;
    if (out_valid && out_ready) begin
      n_xfer++;
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {8'h0, out_data, out_startofpacket, out_endofpacket, out_error,
                                out_empty, grant_id}, 80'h0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {8'h0, out_data, out_startofpacket, out_endofpacket, out_error, out_empty,
                     grant_id}, {8'h0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bit seen;
    int k;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_pkt_active", 80'(pkt_active), 80'(0));
    chk("rst_grant_id", 80'(grant_id), 80'(0));
    chk("rst_orphan_cnt", 80'(orphan_cnt), 80'(0));

    // 1: port 2, 3-beat packet with error on middle beat
    push_pkt(2, 3, 1, 1'b1, 1);
    expect_pkt(2, 3, 1, 1, 3);
    @(negedge clk);
    chk("t1_arb_pkt_active", 80'(pkt_active), 80'(0));
    chk("t1_arb_out_valid", 80'(out_valid), 80'(0));
    chk("t1_arb_in_ready", 80'(in_ready), 80'(0));
    @(negedge clk);
    chk("t1_lock_pkt_active", 80'(pkt_active), 80'(1));
    chk("t1_lock_grant", 80'(grant_id), 80'(2));
    chk("t1_lock_in_ready", 80'(in_ready), 80'(4'b0100));
    wait_drain("t1_drain", 20);
    chk("t1_idle_after", 80'(pkt_active), 80'(0));

    // 2: all ports request single-beat packets; port 0 has two
    do_reset();
    xfer_cyc.delete();
    push_pkt(0, 1, 1, 1'b1, -1); push_pkt(1, 1, 1, 1'b1, -1);
    push_pkt(2, 1, 1, 1'b1, -1); push_pkt(3, 1, 1, 1'b1, -1);
    push_pkt(0, 1, 2, 1'b1, -1);
    expect_pkt(0, 1, 1, -1, 1); expect_pkt(1, 1, 1, -1, 1);
    expect_pkt(2, 1, 1, -1, 1); expect_pkt(3, 1, 1, -1, 1);
    expect_pkt(0, 1, 2, -1, 1);
    wait_drain("t2_drain", 30);
    chk("t2_count", 80'(xfer_cyc.size()), 80'(5));
    for (int i = 1; i < 5 && i < xfer_cyc.size(); i++)
      chk("t2_gap", 80'(xfer_cyc[i] - xfer_cyc[i-1]), 80'(2));

    // 3: port 0 requests while port 1 holds a lock; ports 2 and 3 also wait
    do_reset();
    push_pkt(1, 4, 3, 1'b1, -1);
    expect_pkt(1, 4, 3, -1, 4);
    k = 0;
    while (!pkt_active && k < 10) begin @(negedge clk); k++; end
    chk("t3_locked", 80'(pkt_active), 80'(1));
    push_pkt(0, 1, 3, 1'b1, -1); push_pkt(2, 1, 3, 1'b1, -1); push_pkt(3, 1, 3, 1'b1, -1);
    expect_pkt(2, 1, 3, -1, 1); expect_pkt(3, 1, 3, -1, 1); expect_pkt(0, 1, 3, -1, 1);
    seen = 1'b0;
    k = 0;
    while (pkt_active && k < 20) begin
      if (in_ready[0]) seen = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("t3_port0_blocked", 80'(seen), 80'(0));
    wait_drain("t3_drain", 30);

    // 4: orphan beats on port 3 while idle
    do_reset();
    push_pkt(3, 5, 4, 1'b0, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", 80'(in_ready), 80'(4'b1000));
      chk("t4_out_valid", 80'(out_valid), 80'(0));
    end
    wait_drain("t4_drain", 10);
    chk("t4_orphan_cnt", 80'(orphan_cnt), 80'(5));
    chk("t4_in_ready_idle", 80'(in_ready), 80'(0));

    // 5: extractor backpressure mid-packet, then counter saturation
    do_reset();
    push_pkt(0, 4, 5, 1'b1, -1);
    expect_pkt(0, 4, 5, -1, 4);
    base = n_xfer;
    wait_xfers(base + 2, "t5_two_beats");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_hold_in_ready", 80'(in_ready), 80'(0));
      chk("t5_hold_valid", 80'(out_valid), 80'(1));
      chk("t5_hold_data", 80'(out_data), 80'(make_beat(0, 4, 5, 2, 1'b1, -1).data));
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain("t5_drain", 20);
    chk("t5_xfers", 80'(n_xfer - base), 80'(4));
    push_pkt(1, 20, 6, 1'b0, -1);
    wait_drain("t5_orphan_drain", 40);
    chk("t5_saturate", 80'(orphan_cnt), 80'(4'hF));

    // 6: reset mid-packet, the tail is drained as orphans
    do_reset();
    push_pkt(2, 4, 7, 1'b1, -1);
    expect_pkt(2, 4, 7, -1, 2);
    base = n_xfer;
    wait_xfers(base + 2, "t6_two_beats");
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 80'(out_valid), 80'(0));
    chk("t6_rst_pkt_active", 80'(pkt_active), 80'(0));
    #1 reset_n = 1'b1;
    wait_drain("t6_drain", 20);
    chk("t6_orphan_cnt", 80'(orphan_cnt), 80'(2));
    chk("t6_xfers", 80'(n_xfer - base), 80'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
